// File: rtl/pico_bridge_pkg.sv
// Shared constants for the PicoBus-to-stream bridge.
// Register offsets, CTRL bits and STATUS field layout.
package pico_bridge_pkg;

  localparam logic [3:0] REG_DATA  = 4'h0;
  localparam logic [3:0] REG_CTRL  = 4'h4;
  localparam logic [3:0] REG_DROPS = 4'h8;

  localparam int CTRL_FLUSH_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  localparam int STAT_OVF_BIT  = 0;
  localparam int STAT_LANE_LSB = 2;
  localparam int STAT_LANE_W   = 2;
  localparam int STAT_CNT_LSB  = 8;
  localparam int STAT_CNT_W    = 8;

  function automatic logic [31:0] pack_status(
    input logic [STAT_CNT_W-1:0]  cnt,
    input logic [STAT_LANE_W-1:0] lane,
    input logic                   ovf
  );
    logic [31:0] s;
    s = '0;
    s[STAT_OVF_BIT] = ovf;
    s[STAT_LANE_LSB +: STAT_LANE_W] = lane;
    s[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return s;
  endfunction

endpackage

// File: rtl/pico_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO.
// Push into a full FIFO is accepted only alongside a pop.
module pico_sync_fifo_fwft #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  // Empty head reads as zero so the stream bus idles clean.
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/pico_bus_stream_bridge.sv
// PicoBus slave that packs bus writes into stream beats via a FIFO.
// Define PICO_BRIDGE_DROP_CNT_EN to build the DROPS counter.
module pico_bus_stream_bridge
  import pico_bridge_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR    = 32'h0001_0000,
  parameter int          BUS_WIDTH    = 32,
  parameter int          STREAM_WIDTH = 128,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [31:0]             bus_addr,
  input  logic [BUS_WIDTH-1:0]    bus_din,
  input  logic                    bus_wren,
  input  logic                    bus_rden,
  output logic [BUS_WIDTH-1:0]    bus_dout,
  output logic [STREAM_WIDTH-1:0] s_data,
  output logic                    s_valid,
  input  logic                    s_ready
);

  localparam int LANES = STREAM_WIDTH / BUS_WIDTH;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;

  logic                    sel_data;
  logic                    sel_ctrl;
  logic                    sel_drops;
  logic                    wr_data_hit;
  logic                    wr_ctrl;
  logic                    clear_req;
  logic                    flush_req;
  logic                    push_req;
  logic                    pop;
  logic                    drop;
  logic                    last_lane;
  logic [LW-1:0]           lane_idx;
  logic [STREAM_WIDTH-1:0] asm_q;
  logic [STREAM_WIDTH-1:0] push_beat;
  logic [CW-1:0]           fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    overflow;
  logic [31:0]             drop_cnt;
  logic [31:0]             status;

  assign sel_data  = (bus_addr == BASE_ADDR + 32'(REG_DATA));
  assign sel_ctrl  = (bus_addr == BASE_ADDR + 32'(REG_CTRL));
  assign sel_drops = (bus_addr == BASE_ADDR + 32'(REG_DROPS));

  assign wr_data_hit = bus_wren && sel_data;
  assign wr_ctrl     = bus_wren && sel_ctrl;
  assign clear_req   = wr_ctrl && bus_din[CTRL_CLEAR_BIT];
  assign last_lane   = (lane_idx == LW'(LANES - 1));

  assign flush_req = wr_ctrl
                  && bus_din[CTRL_FLUSH_BIT]
                  && !bus_din[CTRL_CLEAR_BIT]
                  && (lane_idx != '0);

  assign push_req = (wr_data_hit && last_lane) || flush_req;
  assign s_valid  = !fifo_empty;
  assign pop      = s_valid && s_ready;
  assign drop     = push_req && fifo_full && !pop;

  // Unfilled lanes of asm_q are always zero, so a flush needs no masking.
  always_comb begin
    push_beat = asm_q;
    if (wr_data_hit)
      push_beat[lane_idx*BUS_WIDTH +: BUS_WIDTH] = bus_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_idx <= '0;
      asm_q    <= '0;
    end else if (clear_req || push_req) begin
      lane_idx <= '0;
      asm_q    <= '0;
    end else if (wr_data_hit) begin
      asm_q[lane_idx*BUS_WIDTH +: BUS_WIDTH] <= bus_din;
      lane_idx <= lane_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         overflow <= 1'b0;
    else if (clear_req) overflow <= 1'b0;
    else if (drop)      overflow <= 1'b1;
  end

`ifdef PICO_BRIDGE_DROP_CNT_EN
  logic wr_drops;
  assign wr_drops = bus_wren && sel_drops;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= '0;
    else if (wr_drops)
      drop_cnt <= '0;
    else if (drop && (drop_cnt != '1))
      drop_cnt <= drop_cnt + 1'b1;
  end
`else
  assign drop_cnt = '0;
`endif

  assign status = pack_status(
    STAT_CNT_W'(fifo_count),
    STAT_LANE_W'(lane_idx),
    overflow
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_dout <= '0;
    end else begin
      bus_dout <= '0;
      if (bus_rden) begin
        unique case (1'b1)
          sel_ctrl:  bus_dout <= BUS_WIDTH'(status);
          sel_drops: bus_dout <= BUS_WIDTH'(drop_cnt);
          default:   bus_dout <= '0;
        endcase
      end
    end
  end

  pico_sync_fifo_fwft #(
    .WIDTH (STREAM_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (clear_req),
    .wr_en   (push_req),
    .wr_data (push_beat),
    .rd_en   (pop),
    .rd_data (s_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
